ternary_matrix_loader: RTL and testbench

Streaming loader that assembles a `ternary_matrix_t` from a beat-serial stream of 2-bit ternary codes and presents the complete matrix to the matmul datapath. It is the ingest end of the matrix transfer path: upstream sends weights element-serially, and the accelerator consumes them as a full D×D array. It optionally polices the illegal ternary code `2'b10` (value −2). That code never appears in legal weight data.

---
 rtl/config_pkg.sv | 17 +
 rtl/ternary_matrix_loader_lane_check.sv | 19 +
 rtl/ternary_matrix_loader.sv | 115 +++++++++++
 tb/tb_ternary_matrix_loader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared ternary types and loader FSM state for the matrix transfer path.
package config_pkg;

    localparam int unsigned D = 4;

    typedef logic [1:0] ternary_t;
    typedef ternary_t [D-1:0][D-1:0] ternary_matrix_t;

    // Two's-complement -2; never present in legal weight data
    localparam ternary_t TernaryIllegal = 2'b10;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/ternary_matrix_loader_lane_check.sv
// ternary_lane_check: per-lane illegal-code detection and sanitising.
// Behaviour depends on TERNARY_LOADER_ILLEGAL_CHECK_EN.
module ternary_lane_check
    import config_pkg::*;
(
    input  ternary_t code,
    output ternary_t clean_c,
    output logic     illegal_c
);

`ifdef TERNARY_LOADER_ILLEGAL_CHECK_EN
    assign illegal_c = (code == TernaryIllegal);
    assign clean_c   = illegal_c ? ternary_t'(2'b00) : code;
`else
    assign illegal_c = 1'b0;
    assign clean_c   = code;
`endif

endmodule

// File: rtl/ternary_matrix_loader.sv
// ternary_matrix_loader: assembles a D x D ternary matrix from a beat-serial stream.
// Illegal-code policing is enabled by defining TERNARY_LOADER_ILLEGAL_CHECK_EN.
module ternary_matrix_loader
    import config_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [2*LANES-1:0]     in_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output ternary_matrix_t        m_o,
    output logic                   err_o,
    output logic [$clog2(D*D)-1:0] err_idx_o,
    input  logic                   err_clr_i
);

    localparam int unsigned BEATS = D * D / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IDX_W = $clog2(D * D);

    loader_state_t      state;
    logic [CNT_W-1:0]   cnt;
    logic [2*D*D-1:0]   m_q;
    logic [2*LANES-1:0] beat_clean;
    logic [LANES-1:0]   lane_illegal;

    assign m_o = ternary_matrix_t'(m_q);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ternary_lane_check u_check (
            .code      (in_data_i[2*k +: 2]),
            .clean_c   (beat_clean[2*k +: 2]),
            .illegal_c (lane_illegal[k])
        );
    end

    // Flat index f occupies m_q[2f+1:2f], so a beat lands as one contiguous slice
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= FILL;
            cnt        <= '0;
            in_ready_o <= 1'b1;
            m_valid_o  <= 1'b0;
            m_q        <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid_i) begin
                        m_q[int'(cnt) * 2 * LANES +: 2 * LANES] <= beat_clean;
                        if (cnt == CNT_W'(BEATS - 1)) begin
                            cnt        <= '0;
                            state      <= FULL;
                            in_ready_o <= 1'b0;
                            m_valid_o  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (m_ready_i) begin
                        state      <= FILL;
                        in_ready_o <= 1'b1;
                        m_valid_o  <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef TERNARY_LOADER_ILLEGAL_CHECK_EN
    logic             any_illegal_c;
    logic [IDX_W-1:0] first_idx_c;

    // Lowest illegal lane in the current beat wins
    always_comb begin
        any_illegal_c = 1'b0;
        first_idx_c   = '0;
        for (int k = int'(LANES) - 1; k >= 0; k--) begin
            if (lane_illegal[k]) begin
                any_illegal_c = 1'b1;
                first_idx_c   = IDX_W'(int'(cnt) * int'(LANES) + k);
            end
        end
    end

    // A new error at the same edge as a clear takes precedence
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o     <= 1'b0;
            err_idx_o <= '0;
        end else if (in_valid_i && in_ready_o && any_illegal_c) begin
            err_o <= 1'b1;
            if (!err_o || err_clr_i) begin
                err_idx_o <= first_idx_c;
            end
        end else if (err_clr_i) begin
            err_o     <= 1'b0;
            err_idx_o <= '0;
        end
    end
`else
    logic unused_err;

    assign err_o      = 1'b0;
    assign err_idx_o  = '0;
    assign unused_err = ^{err_clr_i, lane_illegal};
`endif

endmodule

// File: tb/tb_ternary_matrix_loader.sv
// Self-checking bench for ternary_matrix_loader (D=4, LANES=2) against a flat-index model.
module tb_ternary_matrix_loader;
    import config_pkg::*;

    localparam int unsigned LANES = 2;
    localparam int unsigned BEATS = D * D / LANES;
    localparam int unsigned IDX_W = $clog2(D * D);

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, m_valid, m_ready, err, err_clr;
    logic [2*LANES-1:0] in_data;
    ternary_matrix_t m;
    logic [IDX_W-1:0] err_idx;

    int pass_cnt = 0;
    int total_cnt = 0;
    ternary_t vals [D*D];

    always #5 clk = ~clk;

    ternary_matrix_loader #(.LANES(LANES)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_data_i (in_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_o       (m),
        .err_o     (err),
        .err_idx_o (err_idx),
        .err_clr_i (err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ternary_t enc(int v);
        if (v == 0) return 2'b00;
        if (v == 1) return 2'b01;
        return 2'b11;
    endfunction

    function automatic ternary_t rnd_legal();
        return enc(int'($urandom_range(0, 2)) - 1);
    endfunction

    // Value the loader is expected to hold for a code that was sent
    function automatic ternary_t stored(ternary_t c);
`ifdef TERNARY_LOADER_ILLEGAL_CHECK_EN
        return (c == TernaryIllegal) ? 2'b00 : c;
`else
        return c;
`endif
    endfunction

    function automatic logic [2*LANES-1:0] beat(int b);
        logic [2*LANES-1:0] r;
        for (int k = 0; k < int'(LANES); k++) r[2*k +: 2] = vals[b * int'(LANES) + k];
        return r;
    endfunction

    // Drives the model's matrix beat by beat; reports stalls and premature m_valid
    task automatic load_matrix(input bit sparse, output int early, output bit tmo, output int cycles);
        early = 0;
        tmo = 1'b0;
        cycles = 0;
        for (int b = 0; b < int'(BEATS) && !tmo; b++) begin
            bit acc;
            int guard;
            acc = 1'b0;
            guard = 0;
            while (!acc && !tmo) begin
                in_valid = sparse ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = in_valid ? beat(b) : (2*LANES)'($urandom);
                if (m_valid === 1'b1) early++;
                acc = in_valid && (in_ready === 1'b1);
                tick();
                cycles++;
                guard++;
                if (!acc && guard > 64) tmo = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", m_valid); else pass_cnt++;
        total_cnt++; if (m !== '0) $display("FAIL reset_m: got %h expected 0", m); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else pass_cnt++;
        total_cnt++; if (err_idx !== '0) $display("FAIL reset_err_idx: got %0d expected 0", err_idx); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        int early, cycles;
        bit tmo;
        for (int f = 0; f < int'(D*D); f++) vals[f] = enc((f % 3 == 2) ? -1 : f % 3);
        load_matrix(1'b0, early, tmo, cycles);
        total_cnt++; if (tmo) $display("FAIL fill_timeout: got stall expected acceptance"); else pass_cnt++;
        total_cnt++; if (early != 0) $display("FAIL fill_early_valid: got %0d cycles expected 0", early); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL fill_latency: got m_valid=%b expected 1", m_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", in_ready); else pass_cnt++;
        for (int i = 0; i < int'(D); i++)
            for (int j = 0; j < int'(D); j++) begin
                total_cnt++;
                if (m[i][j] !== stored(vals[i*D+j])) $display("FAIL fill_elem[%0d][%0d]: got %b expected %b", i, j, m[i][j], stored(vals[i*D+j]));
                else pass_cnt++;
            end
    endtask

    task automatic test_backpressure();
        int early, cycles;
        bit tmo;
        m_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = (2*LANES)'($urandom);
            tick();
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready); else pass_cnt++;
            total_cnt++; if (m_valid !== 1'b1) $display("FAIL bp_m_valid: got %b expected 1", m_valid); else pass_cnt++;
        end
        for (int i = 0; i < int'(D); i++)
            for (int j = 0; j < int'(D); j++) begin
                total_cnt++;
                if (m[i][j] !== stored(vals[i*D+j])) $display("FAIL bp_stable[%0d][%0d]: got %b expected %b", i, j, m[i][j], stored(vals[i*D+j]));
                else pass_cnt++;
            end
        in_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", in_ready); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", m_valid); else pass_cnt++;
        for (int f = 0; f < int'(D*D); f++) vals[f] = rnd_legal();
        load_matrix(1'b0, early, tmo, cycles);
        total_cnt++; if (tmo || m_valid !== 1'b1) $display("FAIL bp_refill_valid: got m_valid=%b expected 1", m_valid); else pass_cnt++;
        for (int i = 0; i < int'(D); i++)
            for (int j = 0; j < int'(D); j++) begin
                total_cnt++;
                if (m[i][j] !== stored(vals[i*D+j])) $display("FAIL bp_refill[%0d][%0d]: got %b expected %b", i, j, m[i][j], stored(vals[i*D+j]));
                else pass_cnt++;
            end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_sparse();
        int early, cycles;
        bit tmo;
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < int'(D*D); f++) vals[f] = rnd_legal();
            m_ready = 1'($urandom_range(0, 1));
            load_matrix(1'b1, early, tmo, cycles);
            total_cnt++; if (tmo) $display("FAIL sparse_timeout: got stall expected acceptance"); else pass_cnt++;
            total_cnt++; if (early != 0) $display("FAIL sparse_early_valid: got %0d cycles expected 0", early); else pass_cnt++;
            total_cnt++; if (m_valid !== 1'b1) $display("FAIL sparse_valid: got %b expected 1", m_valid); else pass_cnt++;
            for (int i = 0; i < int'(D); i++)
                for (int j = 0; j < int'(D); j++) begin
                    total_cnt++;
                    if (m[i][j] !== stored(vals[i*D+j])) $display("FAIL sparse_elem[%0d][%0d]: got %b expected %b", i, j, m[i][j], stored(vals[i*D+j]));
                    else pass_cnt++;
                end
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int early, cycles;
        bit tmo;
        m_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int f = 0; f < int'(D*D); f++) vals[f] = rnd_legal();
            load_matrix(1'b0, early, tmo, cycles);
            total_cnt++; if (cycles != int'(BEATS)) $display("FAIL b2b_fill_cycles: got %0d expected %0d", cycles, BEATS); else pass_cnt++;
            total_cnt++; if (m_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", m_valid); else pass_cnt++;
            total_cnt++; if (m[D-1][D-1] !== stored(vals[D*D-1])) $display("FAIL b2b_last_elem: got %b expected %b", m[D-1][D-1], stored(vals[D*D-1])); else pass_cnt++;
            tick();
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_consume: got %b expected 1", in_ready); else pass_cnt++;
        end
        m_ready = 1'b0;
    endtask

`ifdef TERNARY_LOADER_ILLEGAL_CHECK_EN
    task automatic test_illegal();
        for (int f = 0; f < int'(D*D); f++) vals[f] = rnd_legal();
        vals[7] = TernaryIllegal;
        vals[12] = TernaryIllegal;
        in_valid = 1'b1;
        for (int b = 0; b < int'(BEATS); b++) begin
            in_data = beat(b);
            tick();
            if (b == 2) begin
                total_cnt++; if (err !== 1'b0) $display("FAIL ill_err_before: got %b expected 0", err); else pass_cnt++;
            end
            if (b == 3 || b == 6) begin
                total_cnt++; if (err !== 1'b1) $display("FAIL ill_err_set_b%0d: got %b expected 1", b, err); else pass_cnt++;
                total_cnt++; if (err_idx !== IDX_W'(7)) $display("FAIL ill_idx_b%0d: got %0d expected 7", b, err_idx); else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        total_cnt++; if (m[1][3] !== 2'b00) $display("FAIL ill_m13: got %b expected 00", m[1][3]); else pass_cnt++;
        for (int i = 0; i < int'(D); i++)
            for (int j = 0; j < int'(D); j++) begin
                total_cnt++;
                if (m[i][j] !== stored(vals[i*D+j])) $display("FAIL ill_elem[%0d][%0d]: got %b expected %b", i, j, m[i][j], stored(vals[i*D+j]));
                else pass_cnt++;
            end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        for (int f = 0; f < int'(D*D); f++) vals[f] = rnd_legal();
        vals[2] = TernaryIllegal;
        in_valid = 1'b1;
        for (int b = 0; b < int'(BEATS); b++) begin
            in_data = beat(b);
            err_clr = (b == 1);
            tick();
            err_clr = 1'b0;
            if (b == 1) begin
                total_cnt++; if (err !== 1'b1) $display("FAIL clr_new_err: got %b expected 1", err); else pass_cnt++;
                total_cnt++; if (err_idx !== IDX_W'(2)) $display("FAIL clr_new_idx: got %0d expected 2", err_idx); else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total_cnt++; if (err !== 1'b0 || err_idx !== '0) $display("FAIL clr_only: got err=%b idx=%0d expected 0/0", err, err_idx); else pass_cnt++;
    endtask
`else
    task automatic test_no_check();
        int early, cycles;
        bit tmo;
        for (int f = 0; f < int'(D*D); f++) vals[f] = rnd_legal();
        vals[0] = TernaryIllegal;
        load_matrix(1'b0, early, tmo, cycles);
        total_cnt++; if (m[0][0] !== 2'b10) $display("FAIL nochk_m00: got %b expected 10", m[0][0]); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL nochk_err: got %b expected 0", err); else pass_cnt++;
        total_cnt++; if (err_idx !== '0) $display("FAIL nochk_idx: got %0d expected 0", err_idx); else pass_cnt++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        int early, cycles;
        bit tmo;
        for (int f = 0; f < int'(D*D); f++) vals[f] = rnd_legal();
        in_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            in_data = beat(b);
            tick();
        end
        rst = 1'b1;
        in_data = (2*LANES)'($urandom);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rmid_m_valid: got %b expected 0", m_valid); else pass_cnt++;
        total_cnt++; if (m !== '0) $display("FAIL rmid_m: got %h expected 0", m); else pass_cnt++;
        total_cnt++; if (err !== 1'b0 || err_idx !== '0) $display("FAIL rmid_err: got err=%b idx=%0d expected 0/0", err, err_idx); else pass_cnt++;
        for (int f = 0; f < int'(D*D); f++) vals[f] = rnd_legal();
        load_matrix(1'b0, early, tmo, cycles);
        total_cnt++; if (tmo || early != 0 || m_valid !== 1'b1) $display("FAIL rmid_refill_valid: got m_valid=%b early=%0d expected 1/0", m_valid, early); else pass_cnt++;
        for (int i = 0; i < int'(D); i++)
            for (int j = 0; j < int'(D); j++) begin
                total_cnt++;
                if (m[i][j] !== stored(vals[i*D+j])) $display("FAIL rmid_elem[%0d][%0d]: got %b expected %b", i, j, m[i][j], stored(vals[i*D+j]));
                else pass_cnt++;
            end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        m_ready = 1'b0;
        err_clr = 1'b0;
        test_reset();
        test_fill();
        test_backpressure();
        test_sparse();
        test_back_to_back();
`ifdef TERNARY_LOADER_ILLEGAL_CHECK_EN
        test_illegal();
`else
        test_no_check();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
